read_only_cache_nway: RTL and testbench
=======================================

# read_only_cache_nway

Parametrised N-way set-associative read-only cache that sits between a narrow read client and the line-wide external memory port of the DDR3 controller. It services word reads from cached lines. On a miss it fetches one full line over the external bus. The fill replaces a victim way chosen by per-set round-robin. Adds reset, bulk invalidate and an optional statistics feature.

## Interface
- LINES_W, 128, line and external data width in bits; power of 2, multiple of DATA_W
- DATA_W, 8, client word width; LINES_W/DATA_W ≥ 2
- SET_ADDR_W, 4, log2 of set count
- WAYS, 2, associativity; power of 2, 1–8
- EXT_ADDR_W, 26, external line address width; > SET_ADDR_W
- Derived: OFFSET_W = log2(LINES_W/DATA_W); ADDR_W = EXT_ADDR_W + OFFSET_W; TAG_W = EXT_ADDR_W − SET_ADDR_W
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- read_rq  in  1  read request, sampled only when busy=0
- address  in  ADDR_W  word address
- invalidate  in  1  clear all valid bits
- ext_read_rq  out  1  line fetch request, level, held until completion
- ext_rq_finished  in  1  fetch completion, one-cycle pulse with ext_data valid
- ext_address  out  EXT_ADDR_W  line address of fetch
- ext_data  in  LINES_W  fetched line
- read_data  out  DATA_W  result, valid while finished=1
- finished  out  1  one-cycle completion pulse
- busy  out  1  high whenever state ≠ IDLE
- hit_count, miss_count  out  32  statistics (see Configuration)

## Operation
- Address split: offset = address[OFFSET_W-1:0]; set = next SET_ADDR_W bits; tag = top TAG_W bits. Word k of a line = line[k*DATA_W +: DATA_W], word 0 at LSBs.
- States: IDLE, LOOKUP, FILL.
- IDLE:
  - read_rq=1: register the address and go to LOOKUP.
  - read_rq=0: stay.
- LOOKUP: compare the tag against all ways of the set.
  - Hit (valid and tag equal): register the selected word into read_data, pulse finished, go to IDLE.
  - Miss: assert ext_read_rq, drive ext_address = registered address >> OFFSET_W, go to FILL.
- FILL: hold ext_read_rq and ext_address stable. On ext_rq_finished=1:
  - write ext_data into the victim way; set its tag and valid bit;
  - advance that set's round-robin pointer;
  - read_data = selected word of ext_data; pulse finished; drop ext_read_rq; go to IDLE.
- Victim selection: the lowest-index invalid way; otherwise the set's round-robin pointer. The pointer advances only on fills into a full set.
- Multiple matching ways cannot occur; no priority logic is required.
- invalidate:
  - In IDLE, clears all valid bits and round-robin pointers at the edge. A read_rq on that same edge is dropped, with no finished pulse.
  - In LOOKUP, forces a miss.
  - In FILL, the fill completes and returns data, but the line is written invalid.
- read_rq while busy=1 is ignored. ext_rq_finished outside FILL is ignored.

## Timing
- Reset values:
  - outputs: ext_read_rq=0, ext_address=0, read_data=0, finished=0, busy=0, counters=0;
  - internal: state IDLE, all valid bits 0, all pointers 0.
- Hit latency: read_rq sampled at edge 0; finished=1 in the cycle after edge 1, i.e. 2 cycles.
- Miss latency: ext_read_rq rises after edge 1. If ext_rq_finished is sampled at edge n, finished=1 in the cycle after edge n.
- busy is 0 in the finished cycle, so back-to-back requests are accepted on the edge where finished is high. Throughput is one hit every 2 cycles.
- Reset mid-FILL: ext_read_rq drops asynchronously and no finished pulse is issued.

## Configuration
- RO_CACHE_STATS_EN:
  - Defined: hit_count increments on every hit, miss_count on every miss (counted at LOOKUP exit). Both counters saturate at 2^32−1 and are cleared by rst and by invalidate.
  - Undefined: the ports remain and are tied to 0; no counter logic is synthesised.

## Structure
- Package ro_cache_pkg holds:
  - the state enum;
  - functions computing OFFSET_W, TAG_W and ADDR_W from the parameters.
- Sub-module ro_cache_tag_array holds, per set, the tag, valid and round-robin pointer storage. It provides:
  - a hit vector and hit way index;
  - a victim index;
  - a write port used at FILL completion;
  - a bulk-invalidate input.
- The data array stays in the top level as a memory of 2^SET_ADDR_W × WAYS lines.

## Test plan
- Cold miss then hit (defaults):
  - Read 0x013 with ext_data byte k = 0x10+k → ext_address=0x1, read_data=0x13.
  - Then read 0x015 → hit, finished 2 cycles after read_rq, read_data=0x15, ext_read_rq stays 0.
- Conflict eviction (2 ways):
  - Fill lines 0x000, 0x100, 0x200 (all set 0) → the third fill evicts 0x000.
  - Rereading 0x000 misses; rereading 0x200 hits.
- Invalidate:
  - After filling 0x013, pulse invalidate, then read 0x013 → miss with a new ext_read_rq.
  - invalidate with read_rq on the same IDLE edge → no finished pulse.
- Reset mid-fill: assert rst while ext_read_rq=1 → ext_read_rq=0 immediately. A late ext_rq_finished produces no finished pulse and no valid line.
- Back-to-back hits: read_rq held high across four hits to one line → four finished pulses, two cycles apart, with correct words.
- With RO_CACHE_STATS_EN defined: sequence of 3 misses then 5 hits → miss_count=3, hit_count=5. After invalidate, both counters read 0.

Source files
------------

// File: rtl/ro_cache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ro_cache_pkg
// Purpose  : Shared state encoding and width helpers for the read-only cache.
// Revision : 1.0 - initial release
// ============================================================================
package ro_cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_FILL   = 2'd2
    } state_e;

    function automatic int calc_offset_w(input int lines_w, input int data_w);
        return $clog2(lines_w / data_w);
    endfunction

    function automatic int calc_tag_w(input int ext_addr_w, input int set_addr_w);
        return ext_addr_w - set_addr_w;
    endfunction

    function automatic int calc_addr_w(input int ext_addr_w, input int lines_w, input int data_w);
        return ext_addr_w + calc_offset_w(lines_w, data_w);
    endfunction

    function automatic int calc_way_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ro_cache_tag_array.sv
`default_nettype none
// ============================================================================
// Module   : ro_cache_tag_array
// Purpose  : Per-set tag, valid and round-robin pointer storage with lookup,
//            victim selection, fill write port and bulk invalidate.
// Revision : 1.0 - initial release
// ============================================================================
module ro_cache_tag_array
    import ro_cache_pkg::*;
#(
    parameter int SET_ADDR_W = 4,
    parameter int WAYS       = 2,
    parameter int TAG_W      = 22,
    parameter int WAY_W      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SET_ADDR_W-1:0] set_i,
    input  logic [TAG_W-1:0]      tag_i,
    output logic [WAYS-1:0]       hit_vec_o,
    output logic [WAY_W-1:0]      hit_way_o,
    output logic [WAY_W-1:0]      victim_o,
    input  logic                  wr_en_i,
    input  logic [WAY_W-1:0]      wr_way_i,
    input  logic [TAG_W-1:0]      wr_tag_i,
    input  logic                  wr_valid_i,
    input  logic                  inval_i
);

    localparam int c_SETS = 2 ** SET_ADDR_W;

    logic [TAG_W-1:0] tag_q   [c_SETS][WAYS];
    logic [WAYS-1:0]  valid_q [c_SETS];
    logic [WAY_W-1:0] ptr_q   [c_SETS];

    logic [WAYS-1:0]  w_valid;
    logic             w_full;
    logic [WAY_W-1:0] w_ptr_inc;

    assign w_valid   = valid_q[set_i];
    assign w_full    = &w_valid;
    assign w_ptr_inc = (ptr_q[set_i] == WAY_W'(WAYS - 1)) ? '0 : ptr_q[set_i] + 1'b1;

    generate
        for (genvar g = 0; g < WAYS; g++) begin : g_way
            assign hit_vec_o[g] = w_valid[g] && (tag_q[set_i][g] == tag_i);
        end
    endgenerate

    always_comb begin
        hit_way_o = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (hit_vec_o[i]) begin
                hit_way_o = hit_way_o | WAY_W'(i);
            end
        end
    end

    // Descending scan so the lowest-index invalid way is the last one assigned.
    always_comb begin
        victim_o = ptr_q[set_i];
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!w_valid[i]) begin
                victim_o = WAY_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < c_SETS; s++) begin
                valid_q[s] <= '0;
                ptr_q[s]   <= '0;
            end
        end else if (inval_i) begin
            for (int s = 0; s < c_SETS; s++) begin
                valid_q[s] <= '0;
                ptr_q[s]   <= '0;
            end
        end else if (wr_en_i) begin
            valid_q[set_i][wr_way_i] <= wr_valid_i;
            if (w_full) begin
                ptr_q[set_i] <= w_ptr_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[set_i][wr_way_i] <= wr_tag_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/read_only_cache_nway.sv
`default_nettype none
// ============================================================================
// Module   : read_only_cache_nway
// Purpose  : N-way set-associative read-only word cache with line fills over
//            the external bus. Optional counters: RO_CACHE_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module read_only_cache_nway
    import ro_cache_pkg::*;
#(
    parameter int LINES_W    = 128,
    parameter int DATA_W     = 8,
    parameter int SET_ADDR_W = 4,
    parameter int WAYS       = 2,
    parameter int EXT_ADDR_W = 26
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                read_rq,
    input  logic [calc_addr_w(EXT_ADDR_W, LINES_W, DATA_W)-1:0] address,
    input  logic                                                invalidate,
    output logic                                                ext_read_rq,
    input  logic                                                ext_rq_finished,
    output logic [EXT_ADDR_W-1:0]                               ext_address,
    input  logic [LINES_W-1:0]                                  ext_data,
    output logic [DATA_W-1:0]                                   read_data,
    output logic                                                finished,
    output logic                                                busy,
    output logic [31:0]                                         hit_count,
    output logic [31:0]                                         miss_count
);

    localparam int c_OFFSET_W = calc_offset_w(LINES_W, DATA_W);
    localparam int c_TAG_W    = calc_tag_w(EXT_ADDR_W, SET_ADDR_W);
    localparam int c_ADDR_W   = calc_addr_w(EXT_ADDR_W, LINES_W, DATA_W);
    localparam int c_WAY_W    = calc_way_w(WAYS);
    localparam int c_SETS     = 2 ** SET_ADDR_W;

    state_e                  state_q, state_d;
    logic [c_ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]       read_data_q, read_data_d;
    logic                    finished_q, finished_d;
    logic                    ext_rq_q, ext_rq_d;
    logic [EXT_ADDR_W-1:0]   ext_addr_q, ext_addr_d;

    logic [SET_ADDR_W-1:0]   w_set;
    logic [c_TAG_W-1:0]      w_tag;
    logic [c_OFFSET_W-1:0]   w_off;
    logic [WAYS-1:0]         w_hit_vec;
    logic [c_WAY_W-1:0]      w_hit_way;
    logic [c_WAY_W-1:0]      w_victim;
    logic                    w_lookup_hit;
    logic                    w_fill_done;
    logic [LINES_W-1:0]      w_hit_line;
    logic [DATA_W-1:0]       w_hit_word;
    logic [DATA_W-1:0]       w_fill_word;

    logic [LINES_W-1:0]      data_q [c_SETS][WAYS];

    assign w_set = addr_q[c_OFFSET_W +: SET_ADDR_W];
    assign w_tag = addr_q[c_ADDR_W-1 -: c_TAG_W];
    assign w_off = addr_q[c_OFFSET_W-1:0];

    // Invalidate during lookup turns any hit into a miss.
    assign w_lookup_hit = (state_q == ST_LOOKUP) && (|w_hit_vec) && !invalidate;
    assign w_fill_done  = (state_q == ST_FILL) && ext_rq_finished;

    ro_cache_tag_array #(
        .SET_ADDR_W (SET_ADDR_W),
        .WAYS       (WAYS),
        .TAG_W      (c_TAG_W),
        .WAY_W      (c_WAY_W)
    ) u_tags (
        .clk        (clk),
        .rst        (rst),
        .set_i      (w_set),
        .tag_i      (w_tag),
        .hit_vec_o  (w_hit_vec),
        .hit_way_o  (w_hit_way),
        .victim_o   (w_victim),
        .wr_en_i    (w_fill_done),
        .wr_way_i   (w_victim),
        .wr_tag_i   (w_tag),
        .wr_valid_i (!invalidate),
        .inval_i    (invalidate && (state_q == ST_IDLE))
    );

    always_ff @(posedge clk) begin
        if (w_fill_done) begin
            data_q[w_set][w_victim] <= ext_data;
        end
    end

    assign w_hit_line  = data_q[w_set][w_hit_way];
    assign w_hit_word  = w_hit_line[w_off * DATA_W +: DATA_W];
    assign w_fill_word = ext_data[w_off * DATA_W +: DATA_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            read_data_q <= '0;
            finished_q  <= 1'b0;
            ext_rq_q    <= 1'b0;
            ext_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            read_data_q <= read_data_d;
            finished_q  <= finished_d;
            ext_rq_q    <= ext_rq_d;
            ext_addr_q  <= ext_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        read_data_d = read_data_q;
        finished_d  = 1'b0;
        ext_rq_d    = ext_rq_q;
        ext_addr_d  = ext_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (read_rq && !invalidate) begin
                    addr_d  = address;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (w_lookup_hit) begin
                    read_data_d = w_hit_word;
                    finished_d  = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    ext_rq_d   = 1'b1;
                    ext_addr_d = addr_q[c_ADDR_W-1:c_OFFSET_W];
                    state_d    = ST_FILL;
                end
            end
            ST_FILL: begin
                if (ext_rq_finished) begin
                    read_data_d = w_fill_word;
                    finished_d  = 1'b1;
                    ext_rq_d    = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ext_read_rq = ext_rq_q;
    assign ext_address = ext_addr_q;
    assign read_data   = read_data_q;
    assign finished    = finished_q;
    assign busy        = (state_q != ST_IDLE);

`ifdef RO_CACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (invalidate) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == ST_LOOKUP) begin
            if (w_lookup_hit) begin
                if (hit_cnt_q != 32'hFFFF_FFFF) begin
                    hit_cnt_q <= hit_cnt_q + 32'd1;
                end
            end else if (miss_cnt_q != 32'hFFFF_FFFF) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_read_only_cache_nway.sv
`default_nettype none
// ============================================================================
// Module   : tb_read_only_cache_nway
// Purpose  : Self-checking bench for read_only_cache_nway (default parameters,
//            optional RO_CACHE_STATS_EN counters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_read_only_cache_nway;

    localparam int LINES_W    = 128;
    localparam int DATA_W     = 8;
    localparam int SET_ADDR_W = 4;
    localparam int WAYS       = 2;
    localparam int EXT_ADDR_W = 26;
    localparam int OFFSET_W   = 4;
    localparam int ADDR_W     = EXT_ADDR_W + OFFSET_W;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  read_rq = 1'b0;
    logic [ADDR_W-1:0]     address = '0;
    logic                  invalidate = 1'b0;
    logic                  ext_read_rq;
    logic                  ext_rq_finished = 1'b0;
    logic [EXT_ADDR_W-1:0] ext_address;
    logic [LINES_W-1:0]    ext_data = '0;
    logic [DATA_W-1:0]     read_data;
    logic                  finished;
    logic                  busy;
    logic [31:0]           hit_count;
    logic [31:0]           miss_count;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] sb_q[$];

    read_only_cache_nway #(
        .LINES_W    (LINES_W),
        .DATA_W     (DATA_W),
        .SET_ADDR_W (SET_ADDR_W),
        .WAYS       (WAYS),
        .EXT_ADDR_W (EXT_ADDR_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .read_rq         (read_rq),
        .address         (address),
        .invalidate      (invalidate),
        .ext_read_rq     (ext_read_rq),
        .ext_rq_finished (ext_rq_finished),
        .ext_address     (ext_address),
        .ext_data        (ext_data),
        .read_data       (read_data),
        .finished        (finished),
        .busy            (busy),
        .hit_count       (hit_count),
        .miss_count      (miss_count)
    );

    always #5 clk = ~clk;

    // Memory content: line 0x1 carries bytes 0x10+k; other lines stay distinct.
    function automatic logic [7:0] model_byte(input logic [EXT_ADDR_W-1:0] la, input int k);
        int v;
        v = int'(la[7:0]) * 16 + k + int'(la[11:4]);
        return v[7:0];
    endfunction

    function automatic logic [LINES_W-1:0] model_line(input logic [EXT_ADDR_W-1:0] la);
        logic [LINES_W-1:0] l;
        for (int k = 0; k < LINES_W / DATA_W; k++) l[k*DATA_W +: DATA_W] = model_byte(la, k);
        return l;
    endfunction

    task automatic do_read(input logic [ADDR_W-1:0] a, input bit exp_miss, input string nm);
        logic [EXT_ADDR_W-1:0] exp_la;
        logic [DATA_W-1:0]     exp_w;
        bit saw_ext, done;
        int lat, wait_c;
        exp_la = a[ADDR_W-1:OFFSET_W];
        sb_q.push_back(model_byte(exp_la, int'(a[OFFSET_W-1:0])));
        @(negedge clk); read_rq = 1'b1; address = a;
        @(negedge clk); read_rq = 1'b0;
        saw_ext = 0; done = 0; lat = 0; wait_c = 0;
        while (!done && lat < 60) begin
            @(negedge clk); lat++;
            ext_rq_finished = 1'b0;
            if (finished) done = 1;
            else if (ext_read_rq) begin
                if (!saw_ext) begin
                    checks++;
                    if (ext_address !== exp_la) begin
                        errors++;
                        $display("FAIL %s ext_address got %h want %h", nm, ext_address, exp_la);
                    end
                end
                saw_ext = 1; wait_c++;
                if (wait_c == 3) begin
                    ext_data = model_line(exp_la);
                    ext_rq_finished = 1'b1;
                end
            end
        end
        exp_w = sb_q.pop_front();
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout waiting for finished", nm);
        end else if (read_data !== exp_w) begin
            errors++;
            $display("FAIL %s read_data got %h want %h", nm, read_data, exp_w);
        end
        checks++;
        if (saw_ext !== exp_miss) begin
            errors++;
            $display("FAIL %s miss got %0d want %0d", nm, saw_ext, exp_miss);
        end
        if (!exp_miss) begin
            checks++;
            if (lat !== 1) begin
                errors++;
                $display("FAIL %s hit latency got %0d want 1 cycle after edge 1", nm, lat);
            end
        end
    endtask

    task automatic pulse_invalidate();
        @(negedge clk); invalidate = 1'b1;
        @(negedge clk); invalidate = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({ext_read_rq, ext_address, read_data, finished, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got rq=%b ea=%h rd=%h fin=%b busy=%b want all 0",
                     ext_read_rq, ext_address, read_data, finished, busy);
        end
        checks++;
        if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_counters got %0d/%0d want 0/0", hit_count, miss_count);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b want 0", busy);
        end
    endtask

    task automatic test_cold_miss_hit();
        do_read(30'h013, 1'b1, "cold_miss");
        do_read(30'h015, 1'b0, "warm_hit");
    endtask

    task automatic test_conflict();
        do_read(30'h000, 1'b1, "conf_fill0");
        do_read(30'h100, 1'b1, "conf_fill1");
        do_read(30'h200, 1'b1, "conf_fill2");
        do_read(30'h000, 1'b1, "conf_evicted");
        do_read(30'h200, 1'b0, "conf_kept");
    endtask

    task automatic test_invalidate();
        pulse_invalidate();
        do_read(30'h013, 1'b1, "inval_refill");
    endtask

    task automatic test_inval_same_edge();
        int pulses;
        @(negedge clk); read_rq = 1'b1; invalidate = 1'b1; address = 30'h015;
        @(negedge clk); read_rq = 1'b0; invalidate = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL inval_drop_busy got %b want 0", busy);
        end
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (finished) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL inval_drop_finished got %0d pulses want 0", pulses);
        end
        do_read(30'h015, 1'b1, "inval_drop_miss");
    endtask

    task automatic test_reset_mid_fill();
        bit seen;
        int pulses;
        @(negedge clk); read_rq = 1'b1; address = 30'h300;
        @(negedge clk); read_rq = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (ext_read_rq) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL rmf_request got ext_read_rq=0 want 1");
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (ext_read_rq !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rmf_async_drop got rq=%b busy=%b want 0/0", ext_read_rq, busy);
        end
        @(negedge clk); rst = 1'b0;
        ext_data = model_line(26'h30); ext_rq_finished = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); ext_rq_finished = 1'b0;
            if (finished) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL rmf_late_finish got %0d pulses want 0", pulses);
        end
        do_read(30'h300, 1'b1, "rmf_no_line");
    endtask

    task automatic test_back_to_back();
        logic [ADDR_W-1:0] addrs [4];
        logic [DATA_W-1:0] exp_w;
        int n, last;
        bit saw_ext;
        addrs[0] = 30'h040; addrs[1] = 30'h047; addrs[2] = 30'h04A; addrs[3] = 30'h04F;
        do_read(30'h041, 1'b1, "b2b_fill");
        for (int i = 0; i < 4; i++) sb_q.push_back(model_byte(addrs[i][ADDR_W-1:OFFSET_W], int'(addrs[i][OFFSET_W-1:0])));
        @(negedge clk); read_rq = 1'b1; address = addrs[0];
        n = 0; last = 0; saw_ext = 0;
        for (int cyc = 1; cyc <= 30 && n < 4; cyc++) begin
            @(negedge clk);
            if (ext_read_rq) saw_ext = 1;
            if (finished) begin
                exp_w = sb_q.pop_front();
                checks++;
                if (read_data !== exp_w) begin
                    errors++;
                    $display("FAIL b2b_data%0d got %h want %h", n, read_data, exp_w);
                end
                if (n > 0) begin
                    checks++;
                    if (cyc - last !== 2) begin
                        errors++;
                        $display("FAIL b2b_gap%0d got %0d want 2", n, cyc - last);
                    end
                end
                last = cyc; n++;
                if (n < 4) address = addrs[n];
                else read_rq = 1'b0;
            end
        end
        read_rq = 1'b0;
        checks++;
        if (n !== 4 || saw_ext) begin
            errors++;
            $display("FAIL b2b_count got %0d pulses ext=%b want 4 ext=0", n, saw_ext);
        end
        while (sb_q.size() > 0) void'(sb_q.pop_front());
    endtask

    task automatic test_stats();
`ifdef RO_CACHE_STATS_EN
        pulse_invalidate();
        checks++;
        if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
            errors++;
            $display("FAIL stats_clear0 got %0d/%0d want 0/0", hit_count, miss_count);
        end
        do_read(30'h500, 1'b1, "st_m0");
        do_read(30'h610, 1'b1, "st_m1");
        do_read(30'h720, 1'b1, "st_m2");
        do_read(30'h501, 1'b0, "st_h0");
        do_read(30'h612, 1'b0, "st_h1");
        do_read(30'h723, 1'b0, "st_h2");
        do_read(30'h50F, 1'b0, "st_h3");
        do_read(30'h610, 1'b0, "st_h4");
        checks++;
        if (hit_count !== 32'd5 || miss_count !== 32'd3) begin
            errors++;
            $display("FAIL stats_counts got hit=%0d miss=%0d want 5/3", hit_count, miss_count);
        end
        pulse_invalidate();
        checks++;
        if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
            errors++;
            $display("FAIL stats_clear1 got %0d/%0d want 0/0", hit_count, miss_count);
        end
`else
        checks++;
        if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
            errors++;
            $display("FAIL stats_tied got %0d/%0d want 0/0", hit_count, miss_count);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_cold_miss_hit();
        test_conflict();
        test_invalidate();
        test_inval_same_edge();
        test_reset_mid_fill();
        test_back_to_back();
        test_stats();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
